// File: rtl/hex_word_ascii_serializer.sv
// hex_word_ascii_serializer
// Prints a DATA_WIDTH-bit word as ASCII hex, one character per out_valid/out_ready
// handshake: optional "0x" prefix, digits most-significant nibble first, then an
// optional CR/LF or LF terminator.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. The producer holds its data and valid stable until
// that transfer. Ready never depends combinationally on valid.
`timescale 1ns/1ps
module hex_word_ascii_serializer #(
   parameter int DATA_WIDTH = 16,
   parameter int UPPERCASE  = 0,
   parameter int PREFIX_EN  = 0,
   parameter int TERM_MODE  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [7:0]            out_ascii,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy
);

   localparam int NDIG = DATA_WIDTH / 4;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] CNT_TOP = CW'(NDIG - 1);

   // The state names the character currently presented on out_ascii.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PREFIX0 = 3'd1,
      S_PREFIX1 = 3'd2,
      S_DIGITS  = 3'd3,
      S_TERM_CR = 3'd4,
      S_TERM_LF = 3'd5
   } state_t;

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic [DATA_WIDTH-1:0] r_word;
   logic [7:0]            r_out_ascii;
   logic                  r_out_valid;
   logic                  r_in_ready;

   state_t                w_state_nx;
   logic [CW-1:0]         w_cnt_nx;
   logic [DATA_WIDTH-1:0] w_word_nx;
   logic [7:0]            w_ascii_nx;
   logic                  w_valid_nx;
   logic                  w_ready_nx;
   logic                  w_out_hs;
   logic                  w_accept;

   function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
      logic [7:0] base;
      base = (UPPERCASE != 0) ? 8'h41 : 8'h61;
      if (nib < 4'd10) begin
         return 8'h30 + {4'h0, nib};
      end
      return base + {4'h0, nib} - 8'h0A;
   endfunction

   function automatic logic [7:0] char_of(input state_t st, input logic [CW-1:0] cnt,
                                          input logic [DATA_WIDTH-1:0] word);
      logic [DATA_WIDTH-1:0] sh;
      sh = word >> {cnt, 2'b00};
      case (st)
         S_PREFIX0: return 8'h30;
         S_PREFIX1: return 8'h78;
         S_DIGITS:  return nib_to_ascii(sh[3:0]);
         S_TERM_CR: return 8'h0D;
         S_TERM_LF: return 8'h0A;
         default:   return 8'h00;
      endcase
   endfunction

   assign w_out_hs = r_out_valid & out_ready;
   assign w_accept = in_valid & r_in_ready;

   // Registered state, counter, latched word and all handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_word      <= '0;
         r_out_ascii <= 8'h00;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_cnt       <= w_cnt_nx;
         r_word      <= w_word_nx;
         r_out_ascii <= w_ascii_nx;
         r_out_valid <= w_valid_nx;
         r_in_ready  <= w_ready_nx;
      end
   end

   // Next-state logic: advance one character per output handshake; the last
   // character's handshake returns to IDLE and reopens the input side.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_word_nx  = r_word;
      w_valid_nx = r_out_valid;
      w_ready_nx = r_in_ready;
      w_ascii_nx = r_out_ascii;

      case (r_state)
         S_IDLE: begin
            w_ready_nx = 1'b1;
            if (w_accept) begin
               w_word_nx  = in_data;
               w_ready_nx = 1'b0;
               w_valid_nx = 1'b1;
               w_cnt_nx   = CNT_TOP;
               w_state_nx = (PREFIX_EN != 0) ? S_PREFIX0 : S_DIGITS;
            end
         end
         S_PREFIX0: begin
            if (w_out_hs) w_state_nx = S_PREFIX1;
         end
         S_PREFIX1: begin
            if (w_out_hs) begin
               w_state_nx = S_DIGITS;
               w_cnt_nx   = CNT_TOP;
            end
         end
         S_DIGITS: begin
            if (w_out_hs) begin
               if (r_cnt != '0) begin
                  w_cnt_nx = r_cnt - 1'b1;
               end else if (TERM_MODE == 2) begin
                  w_state_nx = S_TERM_CR;
               end else if (TERM_MODE == 1) begin
                  w_state_nx = S_TERM_LF;
               end else begin
                  w_state_nx = S_IDLE;
                  w_valid_nx = 1'b0;
                  w_ready_nx = 1'b1;
               end
            end
         end
         S_TERM_CR: begin
            if (w_out_hs) w_state_nx = S_TERM_LF;
         end
         S_TERM_LF: begin
            if (w_out_hs) begin
               w_state_nx = S_IDLE;
               w_valid_nx = 1'b0;
               w_ready_nx = 1'b1;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
            w_valid_nx = 1'b0;
            w_ready_nx = 1'b0;
         end
      endcase

      // A stalled character maps back to itself, so out_ascii stays stable.
      if (w_valid_nx) begin
         w_ascii_nx = char_of(w_state_nx, w_cnt_nx, w_word_nx);
      end
   end

   assign in_ready  = r_in_ready;
   assign out_ascii = r_out_ascii;
   assign out_valid = r_out_valid;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_hex_word_ascii_serializer.sv
// Bench for hex_word_ascii_serializer: four instances (default build, 8-bit
// upper-case with prefix and no terminator, 4-bit lower and upper case) share
// clock, reset, in_data and out_ready; sel picks the instance being driven and
// observed. Expected characters come from a string lookup table.
`timescale 1ns/1ps
module tb_hex_word_ascii_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_data;
   logic        in_valid;
   logic        out_ready;
   logic [1:0]  sel;
   logic        bp_en;

   logic        a_in_ready, b_in_ready, c_in_ready, d_in_ready;
   logic [7:0]  a_ascii, b_ascii, c_ascii, d_ascii;
   logic        a_valid, b_valid, c_valid, d_valid;
   logic        a_busy, b_busy, c_busy, d_busy;
   logic        a_in_valid, b_in_valid, c_in_valid, d_in_valid;

   logic        obs_in_ready;
   logic [7:0]  obs_ascii;
   logic        obs_valid;
   logic        obs_busy;

   logic [7:0]  exp_q[$];
   int          vectors;
   int          miscompares;
   string       hex_lc;
   string       hex_uc;

   // clock / reset
   always #5 clk = ~clk;

   assign a_in_valid = in_valid && (sel == 2'd0);
   assign b_in_valid = in_valid && (sel == 2'd1);
   assign c_in_valid = in_valid && (sel == 2'd2);
   assign d_in_valid = in_valid && (sel == 2'd3);

   hex_word_ascii_serializer u_dut_a (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .out_ascii(a_ascii), .out_valid(a_valid),
      .out_ready(out_ready), .busy(a_busy)
   );

   hex_word_ascii_serializer #(.DATA_WIDTH(8), .UPPERCASE(1), .PREFIX_EN(1), .TERM_MODE(0)) u_dut_b (
      .clk(clk), .rst(rst), .in_data(in_data[7:0]), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .out_ascii(b_ascii), .out_valid(b_valid),
      .out_ready(out_ready), .busy(b_busy)
   );

   hex_word_ascii_serializer #(.DATA_WIDTH(4), .UPPERCASE(0), .PREFIX_EN(0), .TERM_MODE(0)) u_dut_c (
      .clk(clk), .rst(rst), .in_data(in_data[3:0]), .in_valid(c_in_valid),
      .in_ready(c_in_ready), .out_ascii(c_ascii), .out_valid(c_valid),
      .out_ready(out_ready), .busy(c_busy)
   );

   hex_word_ascii_serializer #(.DATA_WIDTH(4), .UPPERCASE(1), .PREFIX_EN(0), .TERM_MODE(0)) u_dut_d (
      .clk(clk), .rst(rst), .in_data(in_data[3:0]), .in_valid(d_in_valid),
      .in_ready(d_in_ready), .out_ascii(d_ascii), .out_valid(d_valid),
      .out_ready(out_ready), .busy(d_busy)
   );

   always_comb begin
      case (sel)
         2'd1:    begin obs_in_ready = b_in_ready; obs_ascii = b_ascii; obs_valid = b_valid; obs_busy = b_busy; end
         2'd2:    begin obs_in_ready = c_in_ready; obs_ascii = c_ascii; obs_valid = c_valid; obs_busy = c_busy; end
         2'd3:    begin obs_in_ready = d_in_ready; obs_ascii = d_ascii; obs_valid = d_valid; obs_busy = d_busy; end
         default: begin obs_in_ready = a_in_ready; obs_ascii = a_ascii; obs_valid = a_valid; obs_busy = a_busy; end
      endcase
   end

   // ---------------- model / drivers ----------------
   task automatic push_word(input logic [15:0] d, input int ndig, input bit upper,
                            input bit pfx, input int term);
      logic [3:0] n;
      logic [7:0] ch;
      if (pfx) begin
         exp_q.push_back(8'h30);
         exp_q.push_back(8'h78);
      end
      for (int i = ndig - 1; i >= 0; i--) begin
         n  = d[i*4 +: 4];
         ch = upper ? hex_uc[int'(n)] : hex_lc[int'(n)];
         exp_q.push_back(ch);
      end
      if (term == 2) exp_q.push_back(8'h0D);
      if (term >= 1) exp_q.push_back(8'h0A);
   endtask

   task automatic ready_driver();
      forever begin
         @(posedge clk);
         #1;
         out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   endtask

   // Scoreboard: pops on every output handshake, checks stalled outputs hold.
   task automatic scoreboard_monitor();
      logic       prev_stall;
      logic [7:0] prev_ascii;
      logic [7:0] exp;
      prev_stall = 1'b0;
      prev_ascii = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               vectors++;
               if (obs_valid !== 1'b1 || obs_ascii !== prev_ascii) begin
                  miscompares++;
                  $display("FAIL stall_hold: got valid=%b ascii=%h required valid=1 ascii=%h",
                           obs_valid, obs_ascii, prev_ascii);
               end
            end
            if (obs_valid === 1'b1 && out_ready === 1'b1) begin
               vectors++;
               if (exp_q.size() == 0) begin
                  miscompares++;
                  $display("FAIL unexpected_char: got %h required no character", obs_ascii);
               end else begin
                  exp = exp_q.pop_front();
                  if (obs_ascii !== exp) begin
                     miscompares++;
                     $display("FAIL char: got %h required %h", obs_ascii, exp);
                  end
               end
            end
            prev_stall = (obs_valid === 1'b1) && (out_ready !== 1'b1);
            prev_ascii = obs_ascii;
         end
      end
   endtask

   task automatic send_word(input logic [15:0] d);
      bit got;
      @(posedge clk);
      #1;
      in_data  = d;
      in_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (obs_in_ready === 1'b1) got = 1'b1;
      end
      if (!got) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_timeout: got in_ready=%b required 1", obs_in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d characters outstanding required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      sel = 2'd0;
      @(negedge clk);
      vectors++;
      if ({obs_valid, obs_in_ready, obs_busy, obs_ascii} !== {3'b000, 8'h00}) begin
         miscompares++;
         $display("FAIL reset_outputs: got v=%b r=%b b=%b a=%h required 0 0 0 00",
                  obs_valid, obs_in_ready, obs_busy, obs_ascii);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (obs_in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL ready_before_edge: got %b required 0", obs_in_ready);
      end
      @(negedge clk);
      vectors++;
      if (obs_in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_after_edge: got %b required 1", obs_in_ready);
      end
   endtask

   task automatic test_beef_timing();
      sel = 2'd0;
      push_word(16'hBEEF, 4, 1'b0, 1'b0, 2);
      send_word(16'hBEEF);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         vectors++;
         if ({obs_valid, obs_busy, obs_in_ready} !== 3'b110) begin
            miscompares++;
            $display("FAIL beef_cycle%0d: got v/b/r=%b%b%b required 110", k, obs_valid, obs_busy, obs_in_ready);
         end
      end
      @(negedge clk);
      vectors++;
      if ({obs_valid, obs_busy, obs_in_ready} !== 3'b001) begin
         miscompares++;
         $display("FAIL beef_done: got v/b/r=%b%b%b required 001", obs_valid, obs_busy, obs_in_ready);
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL beef_count: got %0d left required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_prefix_upper();
      sel = 2'd1;
      push_word(16'h000A, 2, 1'b1, 1'b1, 0);
      send_word(16'h000A);
      wait_drain(40);
      @(negedge clk);
      vectors++;
      if ({obs_valid, obs_in_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL prefix_idle: got v/r=%b%b required 01", obs_valid, obs_in_ready);
      end
   endtask

   task automatic test_backpressure();
      sel   = 2'd0;
      bp_en = 1'b1;
      push_word(16'h1234, 4, 1'b0, 1'b0, 2);
      send_word(16'h1234);
      wait_drain(400);
      bp_en = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({obs_valid, obs_in_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL bp_idle: got v/r=%b%b required 01", obs_valid, obs_in_ready);
      end
   endtask

   task automatic test_nibble_sweep();
      for (int u = 0; u < 2; u++) begin
         sel = (u == 0) ? 2'd2 : 2'd3;
         for (int n = 0; n < 16; n++) begin
            push_word(16'(n), 1, (u != 0), 1'b0, 0);
            send_word(16'(n));
            wait_drain(20);
         end
      end
      sel = 2'd0;
   endtask

   task automatic test_reset_mid_word();
      sel = 2'd0;
      push_word(16'hBEEF, 4, 1'b0, 1'b0, 2);
      send_word(16'hBEEF);
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      exp_q.delete();
      vectors++;
      if ({obs_valid, obs_in_ready, obs_busy, obs_ascii} !== {3'b000, 8'h00}) begin
         miscompares++;
         $display("FAIL midword_reset: got v=%b r=%b b=%b a=%h required 0 0 0 00",
                  obs_valid, obs_in_ready, obs_busy, obs_ascii);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({obs_valid, obs_busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL midword_abandon: got v/b=%b%b required 00", obs_valid, obs_busy);
      end
      push_word(16'h0001, 4, 1'b0, 1'b0, 2);
      send_word(16'h0001);
      wait_drain(40);
   endtask

   task automatic test_back_to_back();
      bit got;
      sel = 2'd0;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (obs_in_ready === 1'b1) got = 1'b1;
      end
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL b2b_start: got in_ready=%b required 1", obs_in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      for (int cyc = 0; cyc < 21; cyc++) begin
         @(negedge clk);
         vectors++;
         if (obs_in_ready !== ((cyc % 7) == 0)) begin
            miscompares++;
            $display("FAIL b2b_ready_c%0d: got %b required %b", cyc, obs_in_ready, ((cyc % 7) == 0));
         end
         vectors++;
         if (obs_valid !== ((cyc % 7) != 0)) begin
            miscompares++;
            $display("FAIL b2b_valid_c%0d: got %b required %b", cyc, obs_valid, ((cyc % 7) != 0));
         end
         if ((cyc % 7) == 0) push_word(in_data, 4, 1'b0, 1'b0, 2);
         @(posedge clk);
         #1;
         in_data = 16'($urandom);
      end
      in_valid = 1'b0;
      wait_drain(40);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst         = 1'b1;
      in_data     = '0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      sel         = 2'd0;
      bp_en       = 1'b0;
      vectors     = 0;
      miscompares = 0;
      hex_lc      = "0123456789abcdef";
      hex_uc      = "0123456789ABCDEF";
      fork
         ready_driver();
         scoreboard_monitor();
      join_none

      test_reset();
      test_beef_timing();
      test_prefix_upper();
      test_backpressure();
      test_nibble_sweep();
      test_reset_mid_word();
      test_back_to_back();

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
